// File: rtl/stdp_synapse.sv
// Input synapse stage: weighted sum of pre-synaptic spikes into a saturated 8-bit current,
// with trace-based STDP weight adaptation and a direct weight write port.
module stdp_synapse #(
  parameter int unsigned N_IN      = 4,
  parameter int unsigned AW        = 2,
  parameter int unsigned W_INIT    = 32,
  parameter int unsigned W_MAX     = 255,
  parameter int unsigned TRACE_SET = 128,
  parameter int unsigned TAU_SHIFT = 2,
  parameter int unsigned A_SHIFT   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   pre_spike,
  input  logic              post_spike,
  input  logic              learn_en,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [7:0]        wr_data,
  output logic [7:0]        current,
  output logic [8*N_IN-1:0] weights
);

  localparam int unsigned SUM_W = 12;
  localparam int unsigned ACC_W = 10;
  localparam logic [7:0]  W_MAX_B  = 8'(W_MAX);
  localparam logic [7:0]  W_INIT_B = 8'(W_INIT);
  localparam logic [7:0]  TRACE_B  = 8'(TRACE_SET);

  logic [7:0]       w_q      [N_IN];
  logic [7:0]       w_d      [N_IN];
  logic [7:0]       pre_tr_q [N_IN];
  logic [7:0]       pre_tr_d [N_IN];
  logic [7:0]       post_tr_q;
  logic [7:0]       post_tr_d;
  logic [7:0]       cur_d;
  logic [SUM_W-1:0] sum;
  logic [7:0]       wr_val;

  // Exponential-ish decay; a non-zero trace whose shifted step is 0 still drops by 1
  function automatic logic [7:0] decay(input logic [7:0] tr);
    logic [7:0] step;
    step = tr >> TAU_SHIFT;
    if (tr != 8'd0 && step == 8'd0) decay = tr - 8'd1;
    else                            decay = tr - step;
  endfunction

  function automatic logic [7:0] adapt(input logic [7:0] w, input logic [7:0] dp,
                                       input logic [7:0] dd);
    logic signed [ACC_W-1:0] acc;
    acc = signed'(ACC_W'(w)) + signed'(ACC_W'(dp)) - signed'(ACC_W'(dd));
    if (acc < 10'sd0)                            adapt = 8'd0;
    else if (acc > signed'(ACC_W'(W_MAX_B)))     adapt = W_MAX_B;
    else                                         adapt = acc[7:0];
  endfunction

  assign wr_val = (wr_data > W_MAX_B) ? W_MAX_B : wr_data;

  // Next-state: current from pre-update weights, trace reload/decay, STDP, write override
  always_comb begin
    sum       = '0;
    post_tr_d = post_spike ? TRACE_B : decay(post_tr_q);
    for (int i = 0; i < N_IN; i++) begin
      w_d[i]      = w_q[i];
      pre_tr_d[i] = pre_spike[i] ? TRACE_B : decay(pre_tr_q[i]);
      if (pre_spike[i]) sum = sum + SUM_W'(w_q[i]);
      if (learn_en)
        w_d[i] = adapt(w_q[i],
                       post_spike   ? (pre_tr_q[i] >> A_SHIFT) : 8'd0,
                       pre_spike[i] ? (post_tr_q   >> A_SHIFT) : 8'd0);
      if (wr_en && int'(wr_addr) == i) w_d[i] = wr_val;
    end
    cur_d = (sum > SUM_W'(255)) ? 8'hFF : sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      current   <= 8'd0;
      post_tr_q <= 8'd0;
      for (int i = 0; i < N_IN; i++) begin
        w_q[i]      <= W_INIT_B;
        pre_tr_q[i] <= 8'd0;
      end
    end else begin
      current   <= cur_d;
      post_tr_q <= post_tr_d;
      for (int i = 0; i < N_IN; i++) begin
        w_q[i]      <= w_d[i];
        pre_tr_q[i] <= pre_tr_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_wout
    assign weights[8*g +: 8] = w_q[g];
  end

endmodule

// File: tb/tb_stdp_synapse.sv
// Directed bench for stdp_synapse: a default build plus a 3-input build with W_MAX=200 and
// A_SHIFT=0, so raw trace values (including the decay tail) show up directly in the weights.
module tb_stdp_synapse;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pre_spike;
  logic        post_spike, learn_en, wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  current, current3;
  logic [31:0] weights;
  logic [23:0] weights3;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stdp_synapse u_dut (
    .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .post_spike(post_spike),
    .learn_en(learn_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .current(current), .weights(weights)
  );

  stdp_synapse #(.N_IN(3), .AW(2), .W_MAX(200), .A_SHIFT(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike[2:0]), .post_spike(post_spike),
    .learn_en(learn_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .current(current3), .weights(weights3)
  );

  function automatic logic [7:0] w4(input int i);
    return weights[8*i +: 8];
  endfunction

  function automatic logic [7:0] w3(input int i);
    return weights3[8*i +: 8];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    pre_spike = 4'b0; post_spike = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
  endtask

  task automatic do_reset();
    idle(); rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
  endtask

  task automatic write(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d; tick(); wr_en = 1'b0;
  endtask

  task automatic test_reset();
    learn_en = 1'b0; do_reset();
    n_cmp++; if (current !== 8'd0) begin n_err++; $display("FAIL reset_current: got %0d want 0", current); end
    n_cmp++; if (weights !== {4{8'd32}}) begin n_err++; $display("FAIL reset_weights: got %h want 20202020", weights); end
    n_cmp++; if (weights3 !== {3{8'd32}}) begin n_err++; $display("FAIL reset_weights3: got %h want 202020", weights3); end
    learn_en = 1'b1; repeat (5) tick();
    n_cmp++; if (weights !== {4{8'd32}}) begin n_err++; $display("FAIL idle_weights: got %h want 20202020", weights); end
    n_cmp++; if (current !== 8'd0) begin n_err++; $display("FAIL idle_current: got %0d want 0", current); end
  endtask

  task automatic test_summation();
    learn_en = 1'b0; do_reset();
    pre_spike = 4'b0011; tick();
    n_cmp++; if (current !== 8'd64) begin n_err++; $display("FAIL sum_0011: got %0d want 64", current); end
    n_cmp++; if (current3 !== 8'd64) begin n_err++; $display("FAIL sum3_011: got %0d want 64", current3); end
    pre_spike = 4'b0; tick();
    n_cmp++; if (current !== 8'd0) begin n_err++; $display("FAIL sum_zero: got %0d want 0", current); end
    write(2'd0, 8'd200); write(2'd1, 8'd100);
    n_cmp++; if (w4(0) !== 8'd200 || w4(1) !== 8'd100) begin n_err++; $display("FAIL wr_read: got %0d/%0d want 200/100", w4(0), w4(1)); end
    pre_spike = 4'b0011; tick(); pre_spike = 4'b0;
    n_cmp++; if (current !== 8'd255) begin n_err++; $display("FAIL sum_sat: got %0d want 255", current); end
    n_cmp++; if (current3 !== 8'd255) begin n_err++; $display("FAIL sum3_sat: got %0d want 255", current3); end
    do_reset();
    pre_spike = 4'b1111; tick();
    n_cmp++; if (current !== 8'd128) begin n_err++; $display("FAIL sum_1111: got %0d want 128", current); end
    n_cmp++; if (current3 !== 8'd96) begin n_err++; $display("FAIL sum3_111: got %0d want 96", current3); end
    pre_spike = 4'b0001; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd100; tick(); wr_en = 1'b0;
    n_cmp++; if (current !== 8'd32) begin n_err++; $display("FAIL sum_old_weight: got %0d want 32", current); end
    tick(); pre_spike = 4'b0;
    n_cmp++; if (current !== 8'd100) begin n_err++; $display("FAIL sum_new_weight: got %0d want 100", current); end
  endtask

  task automatic test_potentiation();
    int dly [11] = '{1, 2, 3, 4, 5, 11, 12, 16, 17, 18, 19};
    int seq [19] = '{128, 96, 72, 54, 41, 31, 24, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0};
    int e4, e3;
    for (int k = 0; k < 11; k++) begin
      learn_en = 1'b1; do_reset();
      pre_spike = 4'b0001; tick(); pre_spike = 4'b0;
      repeat (dly[k] - 1) tick();
      post_spike = 1'b1; tick(); post_spike = 1'b0;
      e4 = 32 + (seq[dly[k] - 1] >> 3);
      e3 = 32 + seq[dly[k] - 1];
      n_cmp++; if (w4(0) !== 8'(e4)) begin n_err++; $display("FAIL pot_d%0d: got %0d want %0d", dly[k], w4(0), e4); end
      n_cmp++; if (w3(0) !== 8'(e3)) begin n_err++; $display("FAIL pot3_d%0d: got %0d want %0d", dly[k], w3(0), e3); end
      n_cmp++; if (weights[31:8] !== {3{8'd32}}) begin n_err++; $display("FAIL pot_others_d%0d: got %h want 202020", dly[k], weights[31:8]); end
    end
  endtask

  task automatic test_depression();
    learn_en = 1'b1; do_reset();
    post_spike = 1'b1; tick(); post_spike = 1'b0;
    pre_spike = 4'b0010; tick(); pre_spike = 4'b0;
    n_cmp++; if (w4(1) !== 8'd16) begin n_err++; $display("FAIL dep_w1: got %0d want 16", w4(1)); end
    n_cmp++; if (w4(0) !== 8'd32) begin n_err++; $display("FAIL dep_w0: got %0d want 32", w4(0)); end
    n_cmp++; if (w3(1) !== 8'd0) begin n_err++; $display("FAIL dep3_floor: got %0d want 0", w3(1)); end
    do_reset();
    post_spike = 1'b1; tick(); post_spike = 1'b0; tick();
    pre_spike = 4'b0010; tick(); pre_spike = 4'b0;
    n_cmp++; if (w4(1) !== 8'd20) begin n_err++; $display("FAIL dep_d2: got %0d want 20", w4(1)); end
    do_reset();
    pre_spike = 4'b0001; tick(); pre_spike = 4'b0;
    post_spike = 1'b1; tick();
    pre_spike = 4'b0001; tick(); pre_spike = 4'b0; post_spike = 1'b0;
    n_cmp++; if (w4(0) !== 8'd44) begin n_err++; $display("FAIL both_terms: got %0d want 44", w4(0)); end
    n_cmp++; if (w3(0) !== 8'd128) begin n_err++; $display("FAIL both_terms3: got %0d want 128", w3(0)); end
  endtask

  task automatic test_clamp();
    learn_en = 1'b1; do_reset();
    write(2'd0, 8'd0);
    post_spike = 1'b1; tick(); post_spike = 1'b0;
    pre_spike = 4'b0001; tick(); pre_spike = 4'b0;
    n_cmp++; if (w4(0) !== 8'd0) begin n_err++; $display("FAIL clamp_low: got %0d want 0", w4(0)); end
    n_cmp++; if (w3(0) !== 8'd0) begin n_err++; $display("FAIL clamp3_low: got %0d want 0", w3(0)); end
    do_reset();
    write(2'd2, 8'd250);
    n_cmp++; if (w4(2) !== 8'd250) begin n_err++; $display("FAIL wr_250: got %0d want 250", w4(2)); end
    n_cmp++; if (w3(2) !== 8'd200) begin n_err++; $display("FAIL wr3_clip: got %0d want 200", w3(2)); end
    pre_spike = 4'b0100; tick(); pre_spike = 4'b0;
    post_spike = 1'b1; tick(); post_spike = 1'b0;
    n_cmp++; if (w4(2) !== 8'd255) begin n_err++; $display("FAIL clamp_high: got %0d want 255", w4(2)); end
    n_cmp++; if (w3(2) !== 8'd200) begin n_err++; $display("FAIL clamp3_high: got %0d want 200", w3(2)); end
    write(2'd0, 8'd255);
    n_cmp++; if (w4(0) !== 8'd255) begin n_err++; $display("FAIL wr_255: got %0d want 255", w4(0)); end
    n_cmp++; if (w3(0) !== 8'd200) begin n_err++; $display("FAIL wr3_255: got %0d want 200", w3(0)); end
  endtask

  task automatic test_priority();
    learn_en = 1'b1; do_reset();
    pre_spike = 4'b0011; tick(); pre_spike = 4'b0;
    post_spike = 1'b1; write(2'd0, 8'd77); post_spike = 1'b0;
    n_cmp++; if (w4(0) !== 8'd77 || w4(1) !== 8'd48) begin n_err++; $display("FAIL wr_over_learn: got %0d/%0d want 77/48", w4(0), w4(1)); end
    n_cmp++; if (w3(0) !== 8'd77 || w3(1) !== 8'd160) begin n_err++; $display("FAIL wr3_over_learn: got %0d/%0d want 77/160", w3(0), w3(1)); end
    do_reset();
    write(2'd3, 8'd99);
    n_cmp++; if (weights3 !== {3{8'd32}}) begin n_err++; $display("FAIL wr3_oob: got %h want 202020", weights3); end
    n_cmp++; if (weights !== {8'd99, {3{8'd32}}}) begin n_err++; $display("FAIL wr_addr3: got %h want 63202020", weights); end
    learn_en = 1'b0; do_reset();
    pre_spike = 4'b0001; tick(); pre_spike = 4'b0;
    post_spike = 1'b1; tick(); post_spike = 1'b0;
    n_cmp++; if (weights !== {4{8'd32}} || weights3 !== {3{8'd32}}) begin n_err++; $display("FAIL nolearn_hold: got %h/%h want 20202020/202020", weights, weights3); end
    learn_en = 1'b1; post_spike = 1'b1; tick(); post_spike = 1'b0;
    n_cmp++; if (w4(0) !== 8'd44) begin n_err++; $display("FAIL nolearn_trace: got %0d want 44", w4(0)); end
    n_cmp++; if (w3(0) !== 8'd128) begin n_err++; $display("FAIL nolearn_trace3: got %0d want 128", w3(0)); end
    do_reset();
    pre_spike = 4'b0001; tick(); pre_spike = 4'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    post_spike = 1'b1; tick(); post_spike = 1'b0;
    n_cmp++; if (w4(0) !== 8'd32 || w3(0) !== 8'd32) begin n_err++; $display("FAIL reset_discard: got %0d/%0d want 32/32", w4(0), w3(0)); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vec [5] = '{4'b0001, 4'b0010, 4'b1111, 4'b0000, 4'b0101};
    logic [7:0] exp [5] = '{8'd32, 8'd32, 8'd128, 8'd0, 8'd64};
    learn_en = 1'b0; do_reset();
    for (int k = 0; k < 5; k++) begin
      pre_spike = vec[k]; tick();
      n_cmp++; if (current !== exp[k]) begin n_err++; $display("FAIL b2b_%0d: got %0d want %0d", k, current, exp[k]); end
    end
    pre_spike = 4'b0;
  endtask

  initial begin
    rst_n = 1'b0; learn_en = 1'b0; idle();
    test_reset();
    test_summation();
    test_potentiation();
    test_depression();
    test_clamp();
    test_priority();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stdp_synapse.md
Name: stdp_synapse

Overview:
- Input synapse stage that sits directly upstream of the LIF neuron. It converts N_IN binary pre-synaptic spike lines into the neuron's 8-bit input current.
- Each input has a programmable 8-bit weight. Weights adapt on-line with trace-based STDP, using the neuron's spike output fed back as post_spike.
- Weights can be loaded and read back for configuration and debug.

Parameters:
- N_IN, 4, number of pre-synaptic inputs (2..16)
- AW, 2, weight address width (clog2(N_IN))
- W_INIT, 32, weight value after reset
- W_MAX, 255, upper weight clamp (≤255); lower clamp fixed at 0
- TRACE_SET, 128, trace value loaded on a spike
- TAU_SHIFT, 2, trace decay shift
- A_SHIFT, 3, STDP learning-rate shift

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- pre_spike  in  N_IN  pre-synaptic spike per input, 1-cycle pulses
- post_spike  in  1  neuron spike output fed back
- learn_en  in  1  1 = STDP weight updates enabled
- wr_en  in  1  weight write strobe
- wr_addr  in  AW  weight index to write
- wr_data  in  8  weight write value
- current  out  8  registered synaptic current to neuron
- weights  out  8*N_IN  all weights flattened, weight i at bits [8i+7:8i]

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all weights = W_INIT; all pre traces and the post trace = 0; current = 0.
  - Reset mid-operation discards traces and any learning in progress.
- Current:
  - current(t+1) = min(255, sum of w[i](t) over all i with pre_spike[i](t)=1).
  - Sum is computed at ≥12 bits, then saturated. Latency is 1 cycle.
  - If no input spikes, current = 0 the next cycle.
  - Uses weights before this cycle's update.
- Traces (per input i, plus one post trace; 8-bit, unsigned):
  - on a spike: next = TRACE_SET.
  - otherwise: next = tr − (tr>>TAU_SHIFT). If tr≠0 and tr>>TAU_SHIFT = 0, next = tr−1 instead, so traces always reach 0.
  - Trace 0 stays 0.
  - Traces update regardless of learn_en.
- STDP (learn_en=1); all terms use trace values registered at the start of the cycle, not the same-cycle reload:
  - potentiation: if post_spike, dp[i] = pre_tr[i]>>A_SHIFT.
  - depression: if pre_spike[i], dd[i] = post_tr>>A_SHIFT.
  - w[i] next = clamp(w[i] + dp[i] − dd[i], 0, W_MAX), computed signed at ≥10 bits. No wrap-around ever.
  - simultaneous pre and post on the same input: both terms apply in the same cycle.
- learn_en=0: weights hold, except for writes.
- Writes:
  - wr_en=1 with wr_addr<N_IN: w[wr_addr] next = min(wr_data, W_MAX).
  - A write overrides learning for that index in the same cycle; other indices still learn.
  - wr_addr ≥ N_IN: the write is ignored.
- weights output: reflects registered weights, so a write is visible the cycle after the strobe.
- No handshake: the block accepts new pre_spike every cycle.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles, release -> current=0, every weight=32, no change while inputs idle.
- Summation: pre_spike=0011 for one cycle -> current=64 next cycle, then 0. Write w0=200, w1=100, pre_spike=0011 -> current=255 (saturated). pre_spike=1111 with all weights 32 -> current=128.
- Potentiation and decay: learn_en=1, pre_spike[0] at t, post_spike at t+1 -> w0=48, w1..w3 remain 32. Repeat from reset with post at t+2 (trace 96) -> w0=44.
- Depression: post_spike at t, pre_spike[1] at t+1 -> w1=16. Trace decay check: 128→96→72→54 on consecutive idle cycles. Decay tail, e.g. 3→2→1→0.
- Clamping: write w0=0, then post at t, pre[0] at t+1 -> w0 stays 0. Write w2=250, pre[2] at t, post at t+1 -> w2=255. With W_MAX=200, write 255 -> reads 200.
- Priority and corner cases:
  - wr_en on index 0 in the same cycle as a potentiating post_spike -> w0 = wr_data exactly.
  - wr_addr out of range (N_IN=3 build, addr 3) -> no weight changes.
  - learn_en=0 with pre/post pairs -> weights unchanged while traces still update.
  - rst_n pulse between pre at t and post at t+1 -> no potentiation.
